// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: writeback result-source encodings and load funct3 codes.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: picks byte/halfword/word from an aligned read word
// and flags offsets that are illegal for the access width.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word[7:0];
    case (off)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
    halfSel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{byteSel[7]}}, byteSel};
      F3_LBU:  data = {24'd0, byteSel};
      F3_LH:   data = {{16{halfSel[15]}}, halfSel};
      F3_LHU:  data = {16'd0, halfSel};
      default: data = word;
    endcase
  end

  // funct3[1] set covers every word-type encoding (010, 011, 110, 111).
  assign misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                      (funct3[1] && (off != 2'd0));

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register with stall/flush, load extraction,
// result selection, write-enable qualification and the instret counter.
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic [XLEN_P-1:0] resultM,
  input  logic [XLEN_P-1:0] dm_rdM,
  input  logic [XLEN_P-1:0] pc_plus4M,
  input  logic [4:0]        rdM,
  input  logic              RF_WENM,
  input  logic [1:0]        result_srcM,
  input  logic [2:0]        funct3M,
  input  logic              stallW,
  input  logic              flushW,
  output logic [XLEN_P-1:0] resultW,
  output logic [4:0]        rdW,
  output logic              RF_WENW,
  output logic              validW,
  output logic              misaligned_loadW,
  output logic [CNT_W-1:0]  instret
);

  logic              validReg;
  logic [XLEN_P-1:0] resultReg;
  logic [XLEN_P-1:0] dmReg;
  logic [XLEN_P-1:0] pc4Reg;
  logic [4:0]        rdReg;
  logic              wenReg;
  logic [1:0]        srcReg;
  logic [2:0]        f3Reg;
  logic [CNT_W-1:0]  instretReg;

  logic [31:0] loadData;
  logic        loadMis;
  logic        misalignedW;

  always_ff @(posedge clk) begin
    if (rst || flushW) begin
      validReg  <= 1'b0;
      resultReg <= '0;
      dmReg     <= '0;
      pc4Reg    <= '0;
      rdReg     <= '0;
      wenReg    <= 1'b0;
      srcReg    <= '0;
      f3Reg     <= '0;
    end else if (!stallW) begin
      validReg  <= validM;
      resultReg <= resultM;
      dmReg     <= dm_rdM;
      pc4Reg    <= pc_plus4M;
      rdReg     <= rdM;
      wenReg    <= RF_WENM;
      srcReg    <= result_srcM;
      f3Reg     <= funct3M;
    end
  end

  // The W instruction retires when it leaves: not held, or flushed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      instretReg <= '0;
    end else if (validReg && (!stallW || flushW)) begin
      instretReg <= instretReg + 1'b1;
    end
  end

  load_extend uLoadExtend (
    .word       (dmReg[31:0]),
    .off        (resultReg[1:0]),
    .funct3     (f3Reg),
    .data       (loadData),
    .misaligned (loadMis)
  );

  assign misalignedW = (srcReg == RES_LOAD) && loadMis;

  always_comb begin
    case (srcReg)
      RES_LOAD: resultW = loadData;
      RES_PC4:  resultW = pc4Reg;
      default:  resultW = resultReg;
    endcase
  end

  assign rdW              = rdReg;
  assign validW           = validReg;
  assign misaligned_loadW = validReg && misalignedW;
  assign RF_WENW          = validReg && wenReg && (rdReg != 5'd0) && !misalignedW;
  assign instret          = instretReg;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected W contents, a monitor
// pops and compares whenever new content lands in W.
module tb_wb_stage;
  import rv32i_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic        valid;
    logic        mis;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        validM = 1'b0;
  logic [31:0] resultM = '0, dm_rdM = '0, pc_plus4M = '0;
  logic [4:0]  rdM = '0;
  logic        RF_WENM = 1'b0;
  logic [1:0]  result_srcM = '0;
  logic [2:0]  funct3M = '0;
  logic        stallW = 1'b0, flushW = 1'b0;
  logic [31:0] resultW;
  logic [4:0]  rdW;
  logic        RF_WENW, validW, misaligned_loadW;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;
  wexp_t expQ[$];
  bit done = 1'b0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .validM(validM), .resultM(resultM), .dm_rdM(dm_rdM),
    .pc_plus4M(pc_plus4M), .rdM(rdM), .RF_WENM(RF_WENM), .result_srcM(result_srcM),
    .funct3M(funct3M), .stallW(stallW), .flushW(flushW), .resultW(resultW),
    .rdW(rdW), .RF_WENW(RF_WENW), .validW(validW),
    .misaligned_loadW(misaligned_loadW), .instret(instret)
  );

  task automatic compareW(input string name, input wexp_t e);
    wexp_t a;
    a = '{result: resultW, rd: rdW, wen: RF_WENW, valid: validW, mis: misaligned_loadW};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got res=%h rd=%0d wen=%b v=%b mis=%b, want res=%h rd=%0d wen=%b v=%b mis=%b",
               name, a.result, a.rd, a.wen, a.valid, a.mis,
               e.result, e.rd, e.wen, e.valid, e.mis);
    end else begin
      $display("ok   %s: res=%h rd=%0d wen=%b v=%b mis=%b instret=%0d",
               name, a.result, a.rd, a.wen, a.valid, a.mis, instret);
    end
  endtask

  task automatic checkInstret(input string name, input logic [63:0] e);
    checks++;
    if (instret !== e) begin
      failures++;
      $display("FAIL %s: instret got %h want %h", name, instret, e);
    end else begin
      $display("ok   %s: instret=%h", name, instret);
    end
  endtask

  // Monitor: classify each edge from the controls seen at it, then check outputs.
  initial begin : monitor
    wexp_t lastW, e;
    bit newW, holdW;
    lastW = '0;
    while (!done) begin
      @(posedge clk);
      newW  = !rst && !flushW && !stallW && validM;
      holdW = !rst && !flushW && stallW;
      @(negedge clk);
      #1;
      if (newW) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop: W captured an instruction with no expected entry");
        end else begin
          e = expQ.pop_front();
          compareW("capture", e);
          lastW = e;
        end
      end else if (holdW) begin
        compareW("stall-hold", lastW);
      end else begin
        lastW = '0;
        compareW("bubble", lastW);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] res, input logic [31:0] dm,
                       input logic [31:0] pc4, input logic [4:0] rd, input bit wen,
                       input logic [1:0] src, input logic [2:0] f3);
    validM = v; resultM = res; dm_rdM = dm; pc_plus4M = pc4;
    rdM = rd; RF_WENM = wen; result_srcM = src; funct3M = f3;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] res, input logic [31:0] dm, input logic [31:0] pc4,
                       input logic [4:0] rd, input bit wen, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] expRes, input bit expWen,
                       input bit expMis);
    drive(1'b1, res, dm, pc4, rd, wen, src, f3);
    expQ.push_back('{result: expRes, rd: rd, wen: expWen, valid: 1'b1, mis: expMis});
    step();
  endtask

  task automatic bubble();
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
    step();
  endtask

  localparam logic [31:0] DM = 32'h80FF_7F01;

  initial begin : stimulus
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    #1 checkInstret("reset", 64'd0);
    rst = 1'b0;

    issue(32'h0000_1234, '0, '0, 5'd5, 1'b1, RES_ALU, 3'b000, 32'h0000_1234, 1'b1, 1'b0);
    #1 checkInstret("alu-in-w", 64'd0);
    bubble();
    #1 checkInstret("alu-left", 64'd1);

    issue(32'h0000_1003, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LB,  32'hFFFF_FF80, 1'b1, 1'b0);
    issue(32'h0000_1001, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LBU, 32'h0000_007F, 1'b1, 1'b0);
    issue(32'h0000_1002, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LH,  32'hFFFF_80FF, 1'b1, 1'b0);
    issue(32'h0000_1000, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LHU, 32'h0000_7F01, 1'b1, 1'b0);
    issue(32'h0000_1000, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LW,  32'h80FF_7F01, 1'b1, 1'b0);
    issue(32'h0000_1002, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LW,  32'h80FF_7F01, 1'b0, 1'b1);
    issue(32'h0000_1001, DM, '0, 5'd6, 1'b1, RES_LOAD, F3_LH,  32'h0000_7F01, 1'b0, 1'b1);
    issue(32'h0000_ABCD, '0, '0, 5'd0, 1'b1, RES_ALU, 3'b000, 32'h0000_ABCD, 1'b0, 1'b0);
    issue(32'h0000_5555, '0, 32'h0000_0104, 5'd1, 1'b1, RES_PC4, 3'b000, 32'h0000_0104, 1'b1, 1'b0);
    issue(32'h0000_0077, '0, 32'h0000_0999, 5'd2, 1'b1, 2'b11, 3'b000, 32'h0000_0077, 1'b1, 1'b0);
    bubble();
    #1 checkInstret("after-loads", 64'd11);

    issue(32'h0000_C0DE, '0, '0, 5'd3, 1'b1, RES_ALU, 3'b000, 32'h0000_C0DE, 1'b1, 1'b0);
    stallW = 1'b1;
    drive(1'b1, 32'h0000_D00D, '0, '0, 5'd8, 1'b1, RES_ALU, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 checkInstret("stalled", 64'd11);
    end
    stallW = 1'b0;
    issue(32'h0000_D00D, '0, '0, 5'd8, 1'b1, RES_ALU, 3'b000, 32'h0000_D00D, 1'b1, 1'b0);
    #1 checkInstret("stall-release", 64'd12);
    stallW = 1'b1;
    flushW = 1'b1;
    drive(1'b1, 32'h0000_EEEE, '0, '0, 5'd9, 1'b1, RES_ALU, 3'b000);
    step();
    #1 checkInstret("stall+flush", 64'd13);
    stallW = 1'b0;
    flushW = 1'b0;
    bubble();
    #1 checkInstret("idle", 64'd13);

    issue(32'h0000_F00F, '0, '0, 5'd4, 1'b1, RES_ALU, 3'b000, 32'h0000_F00F, 1'b1, 1'b0);
    stallW = 1'b1;
    force dut.instretReg = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.instretReg;
    #1 checkInstret("preload", 64'hFFFF_FFFF_FFFF_FFFF);
    stallW = 1'b0;
    bubble();
    #1 checkInstret("wrap", 64'd0);

    issue(32'h0000_0A0A, '0, '0, 5'd7, 1'b1, RES_ALU, 3'b000, 32'h0000_0A0A, 1'b1, 1'b0);
    issue(32'h0000_0B0B, '0, '0, 5'd10, 1'b1, RES_ALU, 3'b000, 32'h0000_0B0B, 1'b1, 1'b0);
    stallW = 1'b1;
    step();
    #1 checkInstret("pre-reset-stall", 64'd1);
    rst = 1'b1;
    step();
    #1 checkInstret("reset-mid-stall", 64'd0);
    rst = 1'b0;
    stallW = 1'b0;
    bubble();

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries never observed, want 0", expQ.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I 5-stage pipeline; sits directly downstream of the memory stage.
- Contains the MEM/WB pipeline register with stall/flush.
- Aligns and sign/zero-extends load data, selects the writeback result, and gates the register-file write enable.
- Keeps a 64-bit retired-instruction counter; resultW doubles as the W-stage forwarding source for EX.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- CNT_W, 64, width of the instret counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- validM  input  1  M stage holds a real instruction.
- resultM  input  32  ALU result / effective address from the memory stage.
- dm_rdM  input  32  aligned data-memory read word for address resultM[31:2], valid in the M cycle.
- pc_plus4M  input  32  PC+4 of the M instruction (JAL/JALR link).
- rdM  input  5  destination register.
- RF_WENM  input  1  instruction writes rd.
- result_srcM  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- funct3M  input  3  load width/sign.
- stallW  input  1  hold the W register.
- flushW  input  1  insert a bubble into W.
- resultW  output  32  writeback data to the register file and forwarding mux.
- rdW  output  5  writeback register index.
- RF_WENW  output  1  qualified register-file write enable.
- validW  output  1  W holds a real instruction.
- misaligned_loadW  output  1  W holds a misaligned load (write suppressed).
- instret  output  64  retired-instruction count.

Behaviour:
- Reset (rst=1 at the clock edge): all W registers cleared.
  - resultW=0, rdW=0, RF_WENW=0, validW=0, misaligned_loadW=0, instret=0.
- Register update priority per edge: rst > flushW > stallW > capture.
  - Capture registers validM, resultM, dm_rdM, pc_plus4M, rdM, RF_WENM, result_srcM, funct3M.
  - Flush loads zeros into all fields (a bubble).
  - Stall holds all fields.
- Latency: exactly one clock from M inputs to W outputs. All outputs are combinational from the W register only, with no input-to-output paths.
- Load extraction uses the registered byte offset off = resultW_reg[1:0] and word dm_rdW.
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend halfword[off[1]].
  - 101 LHU: zero-extend halfword[off[1]].
  - 010, 011, 110, 111: full word.
- Misaligned load: result_src=01 and either:
  - LH/LHU with off[0]=1, or
  - word-type with off != 0.
  - Effect: misaligned_loadW=validW, RF_WENW forced 0, and resultW still shows the extracted value.
- resultW mux: 01 → extracted load data; 10 → pc_plus4; 00/11 → ALU result.
- RF_WENW = valid & wen & (rd != 0) & ~misaligned. A write to x0 is never asserted.
- instret increments by 1 at an edge when valid_reg & (~stallW | flushW), i.e. the W instruction leaves the stage.
  - A stalled instruction is counted once, on the cycle it leaves.
  - A bubble is never counted.
  - Misaligned loads are counted (they retire as trapped-free no-writes).
  - The counter wraps modulo 2^64 with no saturation.
- Simultaneous flushW and stallW: flush wins; the W instruction is counted.
- rst asserted mid-stall: reset wins; instret returns to 0.

Decomposition:
- Shared package (rv32i_pkg):
  - RES_ALU/RES_LOAD/RES_PC4 encodings.
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN.
- Sub-module load_extend: combinational aligner with inputs word[31:0], off[1:0], funct3[2:0] and outputs data[31:0], misaligned. It is reused by any future cache/LSU path.
- wb_stage holds the pipeline register, result mux, enable gating and counter.

Test Plan:
- Reset then capture: rst 2 cycles, then validM=1, RF_WENM=1, rdM=5, result_srcM=00, resultM=0x0000_1234 → next cycle resultW=0x1234, rdW=5, RF_WENW=1; following edge instret=1.
- Loads, dm_rdM=0x80FF_7F01 and result_src=01:
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=1 → 0x0000_007F.
  - LH off=2 → 0xFFFF_80FF.
  - LHU off=0 → 0x0000_7F01.
  - LW off=0 → 0x80FF_7F01.
- Misaligned: LW with resultM=0x0000_1002 → RF_WENW=0, misaligned_loadW=1, instret still increments. LH at 0x1001 gives the same response.
- x0 and JAL: rdM=0, RF_WENM=1 → RF_WENW=0. Then result_src=10, pc_plus4M=0x0000_0104, rdM=1 → resultW=0x104, RF_WENW=1.
- Stall/flush: hold stallW=1 for 3 cycles with a valid instruction in W → outputs constant and instret unchanged; release → instret +1 exactly once. Assert stallW=1 and flushW=1 together → validW=0 next cycle and instret +1.
- Wrap and mid-operation reset: preload the counter via 2^64-1 retirements (force/backdoor), retire one → instret=0. Assert rst with a valid stalled instruction in W → all outputs 0 next cycle.
